neopixel_strand_engine: RTL and testbench

Parametrised successor to the current fixed 8-pixel NeoPixel strand controller. It holds a double-buffered colour frame for NUM_PIXELS pixels of NUM_COLORS channels (GRB or GRBW) and serialises it onto one WS281x data line with cycle-exact bit timing. New features over the previous controller: global brightness scaling, load-while-sending, auto-refresh and out-of-range load rejection. It sits between the switch/key input logic and the GPIO pin in the top-level chip interface.

---
 rtl/neopixel_strand_engine_if.sv | 27 ++
 rtl/neopixel_strand_engine.sv | 108 ++++++++++
 tb/tb_neopixel_strand_engine.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_strand_engine_if.sv
// neopixel_strand_engine_if: load, send and strand-status signals of the strand engine
interface neopixel_strand_engine_if #(
  parameter int NUM_PIXELS = 8,
  parameter int COLOR_BITS = 8
);
  localparam int PW = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1;
  logic [PW-1:0] pixel_index;
  logic [1:0] color_index;
  logic [COLOR_BITS-1:0] color_level;
  logic load_color;
  logic [7:0] brightness;
  logic send_it;
  logic auto_refresh;
  logic neo_data;
  logic ready_to_load;
  logic ready_to_send;
  logic load_error;
  logic frame_done;
  modport master (
    output pixel_index, color_index, color_level, load_color, brightness, send_it, auto_refresh,
    input neo_data, ready_to_load, ready_to_send, load_error, frame_done
  );
  modport slave (
    input pixel_index, color_index, color_level, load_color, brightness, send_it, auto_refresh,
    output neo_data, ready_to_load, ready_to_send, load_error, frame_done
  );
endinterface

// File: rtl/neopixel_strand_engine.sv
// neopixel_strand_engine: double-buffered, brightness-scaled WS281x strand serialiser
module neopixel_strand_engine #(
  parameter int NUM_PIXELS = 8,
  parameter int NUM_COLORS = 3,
  parameter int COLOR_BITS = 8,
  parameter int T0H = 18,
  parameter int T1H = 35,
  parameter int T_BIT = 63,
  parameter int T_LATCH = 2500
) (
  input logic clock,
  input logic reset_n,
  neopixel_strand_engine_if.slave bus
);
  localparam int PW = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1;
  localparam int BW = COLOR_BITS > 1 ? $clog2(COLOR_BITS) : 1;
  localparam int CW = $clog2((T_LATCH > T_BIT ? T_LATCH : T_BIT) + 1);
  typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW, LATCH} state_t;
  state_t state;
  logic [COLOR_BITS-1:0] back_buf [NUM_PIXELS][NUM_COLORS];
  logic [COLOR_BITS-1:0] front_buf [NUM_PIXELS][NUM_COLORS];
  logic [PW-1:0] pix;
  logic [1:0] ch;
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] cnt;
  logic [7:0] bright;
  logic load_ok;
  logic [COLOR_BITS+7:0] product;
  logic [COLOR_BITS-1:0] scaled;
  logic cur_bit;
  logic last_bit;
  logic [CW-1:0] high_len;
  assign load_ok = int'(bus.pixel_index) < NUM_PIXELS && int'(bus.color_index) < NUM_COLORS;
  // level*(brightness+1) never exceeds COLOR_BITS+8 bits, so the top bit is not needed
  assign product = (COLOR_BITS+8)'(front_buf[pix][ch]) * (COLOR_BITS+8)'({1'b0, bright} + 9'd1);
  assign scaled = COLOR_BITS'(product >> 8);
  assign cur_bit = scaled[bit_idx];
  assign high_len = cur_bit ? CW'(T1H) : CW'(T0H);
  assign last_bit = bit_idx == '0 && int'(ch) == NUM_COLORS-1 && int'(pix) == NUM_PIXELS-1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      back_buf <= '{default: '0};
      bus.ready_to_load <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.ready_to_load <= 1'b1;
      bus.load_error <= bus.load_color && bus.ready_to_load && !load_ok;
      if (bus.load_color && bus.ready_to_load && load_ok)
        back_buf[bus.pixel_index][bus.color_index] <= bus.color_level;
    end
  // one counter spans the whole bit window; the high/low split is a compare point inside it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= LATCH;
      front_buf <= '{default: '0};
      cnt <= '0;
      pix <= '0;
      ch <= '0;
      bit_idx <= BW'(COLOR_BITS-1);
      bright <= '0;
      bus.neo_data <= 1'b0;
      bus.ready_to_send <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE:
          if (bus.send_it || bus.auto_refresh) begin
            front_buf <= back_buf;
            bright <= bus.brightness;
            cnt <= '0;
            state <= SEND_HIGH;
            bus.neo_data <= 1'b1;
            bus.ready_to_send <= 1'b0;
          end
        SEND_HIGH: begin
          cnt <= cnt + 1'b1;
          if (cnt == high_len - 1'b1) begin
            state <= SEND_LOW;
            bus.neo_data <= 1'b0;
          end
        end
        SEND_LOW:
          if (cnt == CW'(T_BIT-1)) begin
            cnt <= '0;
            bit_idx <= bit_idx == '0 ? BW'(COLOR_BITS-1) : bit_idx - 1'b1;
            if (bit_idx == '0) begin
              ch <= int'(ch) == NUM_COLORS-1 ? '0 : ch + 1'b1;
              if (int'(ch) == NUM_COLORS-1)
                pix <= int'(pix) == NUM_PIXELS-1 ? '0 : pix + 1'b1;
            end
            state <= last_bit ? LATCH : SEND_HIGH;
            bus.neo_data <= !last_bit;
          end else
            cnt <= cnt + 1'b1;
        LATCH: begin
          cnt <= cnt + 1'b1;
          bus.frame_done <= cnt == CW'(T_LATCH-2);
          if (cnt == CW'(T_LATCH-1)) begin
            cnt <= '0;
            state <= IDLE;
            bus.ready_to_send <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_neopixel_strand_engine.sv
// tb_neopixel_strand_engine: randomized checks of the strand engine against a frame-level model
module tb_neopixel_strand_engine;
  localparam int NP = 5, NC = 3, LT = 500;
  localparam int NP2 = 2, NC2 = 4, LT2 = 100;
  localparam int T0H = 18, T1H = 35, T_BIT = 63;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int m3 [NP][NC];
  int m4 [NP2][NC2];
  bit cap_q [$];
  neopixel_strand_engine_if #(.NUM_PIXELS(NP), .COLOR_BITS(8)) b3 ();
  neopixel_strand_engine_if #(.NUM_PIXELS(NP2), .COLOR_BITS(8)) b4 ();
  neopixel_strand_engine #(.NUM_PIXELS(NP), .NUM_COLORS(NC), .T_LATCH(LT)) dut3 (
    .clock(clk), .reset_n(reset_n), .bus(b3));
  neopixel_strand_engine #(.NUM_PIXELS(NP2), .NUM_COLORS(NC2), .T_LATCH(LT2)) dut4 (
    .clock(clk), .reset_n(reset_n), .bus(b4));
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit smp(input int i);
    return i < cap_q.size() ? cap_q[i] : 1'b0;
  endfunction

  // expected serial stream: pixel, then channel, then MSB-first bits of the scaled level
  function automatic logic [255:0] model_bits(input int w, input int b);
    logic [255:0] v;
    int k, lvl, s;
    v = '0;
    k = 0;
    for (int p = 0; p < ((w != 0) ? NP2 : NP); p++)
      for (int c = 0; c < ((w != 0) ? NC2 : NC); c++) begin
        if (w != 0) lvl = m4[p][c]; else lvl = m3[p][c];
        s = (lvl * (b + 1)) / 256;
        for (int i = 7; i >= 0; i--) begin
          v[k] = s[i];
          k++;
        end
      end
    return v;
  endfunction

  task automatic load(input int w, input int p, input int c, input int lvl);
    bit ok;
    logic le;
    ok = (w != 0) ? (c < NC2) : (p < NP && c < NC);
    if (w != 0) begin
      b4.pixel_index = 1'(p); b4.color_index = 2'(c); b4.color_level = 8'(lvl); b4.load_color = 1'b1;
    end else begin
      b3.pixel_index = 3'(p); b3.color_index = 2'(c); b3.color_level = 8'(lvl); b3.load_color = 1'b1;
    end
    tick();
    b3.load_color = 1'b0;
    b4.load_color = 1'b0;
    le = (w != 0) ? b4.load_error : b3.load_error;
    total_cnt++;
    if (le !== !ok) $display("FAIL load_error dut%0d p%0d c%0d: got %b want %b", w, p, c, le, !ok);
    else pass_cnt++;
    if (ok) begin
      if (w != 0) m4[p][c] = lvl; else m3[p][c] = lvl;
    end
    tick();
    le = (w != 0) ? b4.load_error : b3.load_error;
    total_cnt++;
    if (le !== 1'b0) $display("FAIL load_error_width dut%0d: got %b want 0", w, le);
    else pass_cnt++;
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (((w != 0) ? b4.ready_to_send : b3.ready_to_send) !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n >= 20000) $display("FAIL wait_idle dut%0d: ready_to_send not 1 after %0d cycles", w, n);
    else pass_cnt++;
  endtask

  task automatic send(input int w, input bit ld, input int p, input int c, input int lvl);
    logic nd;
    wait_idle(w);
    if (w != 0) b4.send_it = 1'b1; else b3.send_it = 1'b1;
    if (ld) begin
      b3.pixel_index = 3'(p); b3.color_index = 2'(c); b3.color_level = 8'(lvl); b3.load_color = 1'b1;
    end
    tick();
    b3.send_it = 1'b0;
    b4.send_it = 1'b0;
    b3.load_color = 1'b0;
    if (ld) m3[p][c] = lvl;
    nd = (w != 0) ? b4.neo_data : b3.neo_data;
    total_cnt++;
    if (nd !== 1'b1) $display("FAIL first_send_high dut%0d: neo_data got %b want 1", w, nd);
    else pass_cnt++;
  endtask

  // records neo_data from the current (first SEND_HIGH) cycle through frame_done, then decodes it
  task automatic capture(input int w, output logic [255:0] bits, output int bad, output int len,
                         output int first_high, output int rts_hi);
    int n, lt, h;
    bit done;
    n = (w != 0) ? NP2*NC2*8 : NP*NC*8;
    lt = (w != 0) ? LT2 : LT;
    cap_q.delete();
    len = 0; rts_hi = 0; bad = 0; bits = '0; first_high = 0; done = 1'b0;
    while (!done) begin
      cap_q.push_back(((w != 0) ? b4.neo_data : b3.neo_data) === 1'b1);
      len++;
      if (((w != 0) ? b4.ready_to_send : b3.ready_to_send) === 1'b1) rts_hi++;
      if (((w != 0) ? b4.frame_done : b3.frame_done) === 1'b1 || len > n*T_BIT + lt + 20) done = 1'b1;
      else tick();
    end
    for (int k = 0; k < n; k++) begin
      h = 0;
      while (h < T_BIT && smp(k*T_BIT + h)) h++;
      for (int j = h; j < T_BIT; j++) if (smp(k*T_BIT + j)) bad++;
      if (k == 0) first_high = h;
      if (h == T1H) bits[k] = 1'b1;
      else if (h != T0H) bad++;
    end
    for (int i = n*T_BIT; i < len; i++) if (smp(i)) bad++;
  endtask

  task automatic test_reset();
    int n, fd_at;
    logic rtl1;
    n = 0; fd_at = -1; rtl1 = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({b3.neo_data, b3.ready_to_load, b3.ready_to_send, b3.load_error, b3.frame_done} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
               {b3.neo_data, b3.ready_to_load, b3.ready_to_send, b3.load_error, b3.frame_done});
    else pass_cnt++;
    #4 reset_n = 1'b1;
    while (n < LT + 50) begin
      tick();
      n++;
      if (n == 1) rtl1 = b3.ready_to_load;
      if (b3.frame_done === 1'b1) fd_at = n;
      if (b3.ready_to_send === 1'b1) break;
    end
    total_cnt++;
    if (rtl1 !== 1'b1) $display("FAIL reset_ready_to_load: got %b want 1", rtl1); else pass_cnt++;
    total_cnt++;
    if (n != LT) $display("FAIL reset_latch_len: got %0d want %0d", n, LT); else pass_cnt++;
    total_cnt++;
    if (fd_at != LT-1) $display("FAIL reset_frame_done_at: got %0d want %0d", fd_at, LT-1); else pass_cnt++;
    total_cnt++;
    if (b3.neo_data !== 1'b0) $display("FAIL reset_neo_data: got %b want 0", b3.neo_data); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [255:0] exp, got;
    int bad, len, fh, rh;
    load(0, 0, 0, 8'h80);
    b3.brightness = 8'd255;
    exp = model_bits(0, 255);
    send(0, 1'b0, 0, 0, 0);
    capture(0, got, bad, len, fh, rh);
    total_cnt++;
    if (fh != T1H) $display("FAIL basic_bit0_high: got %0d want %0d", fh, T1H); else pass_cnt++;
    total_cnt++;
    if (got !== exp) $display("FAIL basic_bits: got %h want %h", got, exp); else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL basic_timing: got %0d bad windows want 0", bad); else pass_cnt++;
    total_cnt++;
    if (len != NP*NC*8*T_BIT + LT) $display("FAIL basic_len: got %0d want %0d", len, NP*NC*8*T_BIT + LT);
    else pass_cnt++;
    total_cnt++;
    if (rh != 0) $display("FAIL basic_busy: ready_to_send high %0d cycles want 0", rh); else pass_cnt++;
    tick();
    total_cnt++;
    if ({b3.frame_done, b3.ready_to_send} !== 2'b01)
      $display("FAIL basic_after_frame: frame_done,ready got %b want 01", {b3.frame_done, b3.ready_to_send});
    else pass_cnt++;
  endtask

  task automatic test_scaling();
    logic [255:0] exp, got;
    logic [7:0] first;
    int bad, len, fh, rh;
    load(0, 0, 0, 8'hFF);
    repeat (8) load(0, int'($urandom_range(NP-1, 1)), int'($urandom_range(NC-1)), int'($urandom_range(255)));
    b3.brightness = 8'd127;
    exp = model_bits(0, 127);
    send(0, 1'b0, 0, 0, 0);
    capture(0, got, bad, len, fh, rh);
    for (int j = 0; j < 8; j++) first[7-j] = got[j];
    total_cnt++;
    if (first !== 8'h7F) $display("FAIL scaling_pixel0_g: got %h want 7f", first); else pass_cnt++;
    total_cnt++;
    if (got !== exp) $display("FAIL scaling_bits: got %h want %h", got, exp); else pass_cnt++;
    total_cnt++;
    if (bad != 0 || len != NP*NC*8*T_BIT + LT)
      $display("FAIL scaling_frame: got bad=%0d len=%0d want bad=0 len=%0d", bad, len, NP*NC*8*T_BIT + LT);
    else pass_cnt++;
  endtask

  task automatic test_load_during_frame();
    logic [255:0] exp, got;
    logic [7:0] byte_got, byte_exp;
    int bad, len, fh, rh, bb1, bb2;
    bb1 = int'($urandom_range(255));
    bb2 = int'($urandom_range(255, 64));
    b3.brightness = 8'(bb1);
    exp = model_bits(0, bb1);
    send(0, 1'b0, 0, 0, 0);
    fork
      capture(0, got, bad, len, fh, rh);
      begin
        repeat (300) tick();
        load(0, 3, 2, 8'hAA);
        b3.send_it = 1'b1;
        b3.brightness = 8'(bb2);
        tick();
        b3.send_it = 1'b0;
      end
    join
    total_cnt++;
    if (got !== exp || bad != 0) $display("FAIL during_frame_bits: got %h bad=%0d want %h bad=0", got, bad, exp);
    else pass_cnt++;
    total_cnt++;
    if (len != NP*NC*8*T_BIT + LT || rh != 0)
      $display("FAIL during_frame_len: got len=%0d busy_hi=%0d want %0d,0", len, rh, NP*NC*8*T_BIT + LT);
    else pass_cnt++;
    tick();
    repeat (5) tick();
    total_cnt++;
    if ({b3.ready_to_send, b3.neo_data} !== 2'b10)
      $display("FAIL send_not_queued: ready,neo got %b want 10", {b3.ready_to_send, b3.neo_data});
    else pass_cnt++;
    exp = model_bits(0, bb2);
    send(0, 1'b1, 0, 1, int'($urandom_range(255)));
    capture(0, got, bad, len, fh, rh);
    for (int j = 0; j < 8; j++) byte_got[7-j] = got[88+j];
    byte_exp = 8'((170 * (bb2 + 1)) / 256);
    total_cnt++;
    if (byte_got !== byte_exp) $display("FAIL pixel3_b_bits88: got %h want %h", byte_got, byte_exp);
    else pass_cnt++;
    total_cnt++;
    if (got !== exp || bad != 0) $display("FAIL send_with_load_bits: got %h bad=%0d want %h bad=0", got, bad, exp);
    else pass_cnt++;
  endtask

  task automatic test_load_reject();
    logic [255:0] exp, got;
    int bad, len, fh, rh, bb;
    load(0, 5, 0, 8'h11);
    load(0, 7, 2, 8'h22);
    load(0, 1, 3, 8'h33);
    repeat (6) load(0, int'($urandom_range(7)), int'($urandom_range(3)), int'($urandom_range(255)));
    load(1, 0, 3, int'($urandom_range(255)));
    load(1, 1, 3, int'($urandom_range(255)));
    repeat (6) load(1, int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(255)));
    bb = int'($urandom_range(255));
    b4.brightness = 8'(bb);
    exp = model_bits(1, bb);
    send(1, 1'b0, 0, 0, 0);
    capture(1, got, bad, len, fh, rh);
    total_cnt++;
    if (got !== exp || bad != 0) $display("FAIL grbw_bits: got %h bad=%0d want %h bad=0", got, bad, exp);
    else pass_cnt++;
    total_cnt++;
    if (len != NP2*NC2*8*T_BIT + LT2) $display("FAIL grbw_len: got %0d want %0d", len, NP2*NC2*8*T_BIT + LT2);
    else pass_cnt++;
  endtask

  task automatic test_auto_refresh();
    logic [255:0] exp, got;
    int bad, len, fh, rh, ba, bb;
    ba = int'($urandom_range(255));
    bb = int'($urandom_range(255));
    b3.brightness = 8'(ba);
    exp = model_bits(0, ba);
    wait_idle(0);
    b3.auto_refresh = 1'b1;
    tick();
    b3.brightness = 8'(bb);
    capture(0, got, bad, len, fh, rh);
    total_cnt++;
    if (got !== exp || bad != 0 || len != NP*NC*8*T_BIT + LT)
      $display("FAIL auto_frame1: got %h bad=%0d len=%0d want %h", got, bad, len, exp);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({b3.ready_to_send, b3.neo_data} !== 2'b10)
      $display("FAIL auto_idle_cycle: ready,neo got %b want 10", {b3.ready_to_send, b3.neo_data});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({b3.ready_to_send, b3.neo_data} !== 2'b01)
      $display("FAIL auto_restart: ready,neo got %b want 01", {b3.ready_to_send, b3.neo_data});
    else pass_cnt++;
    b3.auto_refresh = 1'b0;
    exp = model_bits(0, bb);
    capture(0, got, bad, len, fh, rh);
    total_cnt++;
    if (got !== exp || bad != 0) $display("FAIL auto_frame2: got %h bad=%0d want %h", got, bad, exp);
    else pass_cnt++;
    repeat (4) tick();
    total_cnt++;
    if ({b3.ready_to_send, b3.neo_data} !== 2'b10)
      $display("FAIL auto_stop: ready,neo got %b want 10", {b3.ready_to_send, b3.neo_data});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [255:0] exp, got;
    int bad, len, fh, rh;
    b3.brightness = 8'd255;
    send(0, 1'b0, 0, 0, 0);
    repeat (5) tick();
    #3 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({b3.neo_data, b3.ready_to_send, b3.ready_to_load} !== 3'b000)
      $display("FAIL reset_mid_bit: neo,ready_send,ready_load got %b want 000",
               {b3.neo_data, b3.ready_to_send, b3.ready_to_load});
    else pass_cnt++;
    m3 = '{default: 0};
    m4 = '{default: 0};
    tick();
    tick();
    #4 reset_n = 1'b1;
    exp = model_bits(0, 255);
    send(0, 1'b0, 0, 0, 0);
    capture(0, got, bad, len, fh, rh);
    total_cnt++;
    if (got !== exp || bad != 0 || len != NP*NC*8*T_BIT + LT)
      $display("FAIL buffers_cleared: got %h bad=%0d len=%0d want %h", got, bad, len, exp);
    else pass_cnt++;
  endtask

  initial begin
    m3 = '{default: 0};
    m4 = '{default: 0};
    b3.pixel_index = '0; b3.color_index = '0; b3.color_level = '0; b3.load_color = 1'b0;
    b3.brightness = '0; b3.send_it = 1'b0; b3.auto_refresh = 1'b0;
    b4.pixel_index = '0; b4.color_index = '0; b4.color_level = '0; b4.load_color = 1'b0;
    b4.brightness = '0; b4.send_it = 1'b0; b4.auto_refresh = 1'b0;
    test_reset();
    test_basic();
    test_scaling();
    test_load_during_frame();
    test_load_reject();
    test_auto_refresh();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end
endmodule
